// File: rtl/traffic_light_ctrl.sv
// Traffic light controller: main road, side road and optional pedestrian walk phase.
// Every timed state loads an 8-bit down-timer with (dwell-1) when it is entered,
// and the state is left only when that timer reaches 0. MAIN_G holds beyond its
// dwell until a side-road car or a pending pedestrian request arrives.
// Build option: define TLC_PED_EN to include the pedestrian logic. Without it,
// ped_req is ignored and PED_WALK can never be reached.
module traffic_light_ctrl #(
  parameter int unsigned GREEN_CYC  = 8,
  parameter int unsigned YELLOW_CYC = 2,
  parameter int unsigned ALLRED_CYC = 1,
  parameter int unsigned WALK_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_side,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    MAIN_G   = 3'd0,
    MAIN_Y   = 3'd1,
    ALLRED1  = 3'd2,
    SIDE_G   = 3'd3,
    SIDE_Y   = 3'd4,
    ALLRED2  = 3'd5,
    PED_WALK = 3'd6
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] timer, timer_nxt;
  logic       ped_pending;

  // Value loaded into the down-timer when a state is entered.
  function automatic logic [7:0] dwell(input state_t s);
    logic [7:0] d;
    case (s)
      MAIN_Y, SIDE_Y:   d = 8'(YELLOW_CYC - 1);
      ALLRED1, ALLRED2: d = 8'(ALLRED_CYC - 1);
      PED_WALK:         d = 8'(WALK_CYC - 1);
      default:          d = 8'(GREEN_CYC - 1);
    endcase
    return d;
  endfunction

  // State and dwell-timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MAIN_G;
      timer <= 8'(GREEN_CYC - 1);
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Next-state selection; the timer reloads on any state change, otherwise it
  // counts down and saturates at 0.
  always_comb begin
    state_nxt = state;
    unique case (state)
      MAIN_G:   if (timer == '0 && (car_side || ped_pending)) state_nxt = MAIN_Y;
      MAIN_Y:   if (timer == '0) state_nxt = ALLRED1;
      ALLRED1:
        if (timer == '0) begin
          if (car_side)         state_nxt = SIDE_G;
          else if (ped_pending) state_nxt = PED_WALK;
          else                  state_nxt = MAIN_G;
        end
      SIDE_G:   if (timer == '0) state_nxt = SIDE_Y;
      SIDE_Y:   if (timer == '0) state_nxt = ALLRED2;
      ALLRED2:  if (timer == '0) state_nxt = MAIN_G;
      PED_WALK: if (timer == '0) state_nxt = ALLRED2;
      default:  state_nxt = MAIN_G;
    endcase
    if (state_nxt != state)  timer_nxt = dwell(state_nxt);
    else if (timer != '0)    timer_nxt = timer - 8'd1;
    else                     timer_nxt = '0;
  end

  // Lamp and debug decode from the current state only.
  always_comb begin
    main_light = 3'b100;
    side_light = 3'b100;
    ped_walk   = 1'b0;
    state_dbg  = state;
    unique case (state)
      MAIN_G:   main_light = 3'b001;
      MAIN_Y:   main_light = 3'b010;
      SIDE_G:   side_light = 3'b001;
      SIDE_Y:   side_light = 3'b010;
      PED_WALK: ped_walk   = 1'b1;
      default:  ;
    endcase
  end

`ifdef TLC_PED_EN
  logic ped_pending_d;
  logic ped_ack_q;

  // Pending request latch: clearing on PED_WALK entry wins over a new request;
  // requests made during the walk are dropped. The ack fires one cycle after
  // the latch rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_pending   <= 1'b0;
      ped_pending_d <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      if (state_nxt == PED_WALK && state != PED_WALK)
        ped_pending <= 1'b0;
      else if (ped_req && state != PED_WALK)
        ped_pending <= 1'b1;
      ped_pending_d <= ped_pending;
      ped_ack_q     <= ped_pending & ~ped_pending_d;
    end
  end

  assign ped_ack = ped_ack_q;
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign ped_pending    = 1'b0;
  assign ped_ack        = 1'b0;
`endif

endmodule
